// File: rtl/timer_pkg.sv
// Shared mode encodings for the multi-channel timer.
// Mode values match the per-channel two-bit ch_mode field.
package timer_pkg;

  localparam logic [1:0] MODE_REPEAT_UP = 2'b00;
  localparam logic [1:0] MODE_ONESHOT   = 2'b01;
  localparam logic [1:0] MODE_DOWN      = 2'b10;
  localparam logic [1:0] MODE_UPDOWN    = 2'b11;

  typedef enum logic [1:0] {
    TM_REPEAT_UP = MODE_REPEAT_UP,
    TM_ONESHOT   = MODE_ONESHOT,
    TM_DOWN      = MODE_DOWN,
    TM_UPDOWN    = MODE_UPDOWN
  } timer_mode_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: count, direction, busy, expire pulse and sticky irq.
// Counting happens on prescaler ticks; disable, trig and irq_clr act every clk.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_en,
  input  timer_mode_t      i_mode,
  input  logic [CNT_W-1:0] i_max,
  input  logic             i_trig,
  input  logic             i_irq_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_expire,
  output logic             o_busy,
  output logic             o_irq
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_busy;
  logic             r_exp;
  logic             r_irq;

  logic [CNT_W-1:0] w_cnt;
  logic             w_dir;
  logic             w_busy;
  logic             w_exp;
  logic             w_irq;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_dec;

  assign w_inc = r_cnt + CNT_W'(1);
  assign w_dec = r_cnt - CNT_W'(1);

  always_comb begin
    w_cnt  = r_cnt;
    w_dir  = r_dir;
    w_busy = r_busy;
    w_exp  = 1'b0;
    if (!i_en) begin
      w_cnt  = (i_mode == TM_DOWN) ? i_max : '0;
      w_dir  = 1'b0;
      w_busy = 1'b0;
    end else begin
      unique case (i_mode)
        TM_REPEAT_UP: begin
          w_busy = 1'b1;
          if (i_tick) begin
            if (r_cnt >= i_max) begin
              w_cnt = '0;
              w_exp = 1'b1;
            end else begin
              w_cnt = w_inc;
            end
          end
        end
        TM_ONESHOT: begin
          if (i_trig && !r_busy) begin
            w_cnt  = '0;
            w_busy = 1'b1;
          end else if (i_tick && r_busy) begin
            if (r_cnt >= i_max) begin
              w_exp  = 1'b1;
              w_busy = 1'b0;
            end else begin
              w_cnt = w_inc;
            end
          end
        end
        TM_DOWN: begin
          w_busy = 1'b1;
          if (i_tick) begin
            if (r_cnt == '0 || r_cnt > i_max) begin
              w_cnt = i_max;
              w_exp = (r_cnt == '0);
            end else begin
              w_cnt = w_dec;
            end
          end
        end
        TM_UPDOWN: begin
          w_busy = 1'b1;
          if (i_tick) begin
            // dir: 0 = up, 1 = down; a max lowered below cnt clamps and turns down
            if (i_max == '0) begin
              w_cnt = '0;
              w_dir = 1'b0;
              w_exp = 1'b1;
            end else if (r_cnt > i_max) begin
              w_cnt = i_max;
              w_dir = 1'b1;
              w_exp = 1'b1;
            end else if (!r_dir) begin
              if (r_cnt == i_max) begin
                w_cnt = w_dec;
                w_dir = 1'b1;
              end else begin
                w_cnt = w_inc;
                if (w_inc == i_max) begin
                  w_dir = 1'b1;
                  w_exp = 1'b1;
                end
              end
            end else begin
              if (r_cnt == '0) begin
                w_cnt = CNT_W'(1);
                w_dir = 1'b0;
              end else begin
                w_cnt = w_dec;
                if (w_dec == '0) w_dir = 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_irq = (r_irq & ~i_irq_clr) | w_exp;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_busy <= 1'b0;
      r_exp  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt;
      r_dir  <= w_dir;
      r_busy <= w_busy;
      r_exp  <= w_exp;
      r_irq  <= w_irq;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_expire = r_exp;
  assign o_busy   = r_busy;
  assign o_irq    = r_irq;

endmodule

// File: rtl/timer_multi_ch.sv
// N-channel programmable timer with a shared prescaler.
// Each channel runs one of four counting modes and raises expire/irq.
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PSC_W-1:0]      cfg_psc,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [2*N_CH-1:0]     ch_mode,
  input  logic [CNT_W*N_CH-1:0] ch_max,
  input  logic [N_CH-1:0]       ch_trig,
  input  logic [N_CH-1:0]       irq_clr,
  output logic [CNT_W*N_CH-1:0] cnt,
  output logic [N_CH-1:0]       expire,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       irq
);

  logic [PSC_W-1:0] r_psc;
  logic             w_any_en;
  logic             w_tick;

  assign w_any_en = |ch_en;
  // >= lets a lowered cfg_psc wrap at once instead of running past it
  assign w_tick   = w_any_en && (r_psc >= cfg_psc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc <= '0;
    end else if (!w_any_en || w_tick) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + PSC_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .i_rst     (rst),
      .i_tick    (w_tick),
      .i_en      (ch_en[g]),
      .i_mode    (timer_mode_t'(ch_mode[2*g +: 2])),
      .i_max     (ch_max[CNT_W*g +: CNT_W]),
      .i_trig    (ch_trig[g]),
      .i_irq_clr (irq_clr[g]),
      .o_cnt     (cnt[CNT_W*g +: CNT_W]),
      .o_expire  (expire[g]),
      .o_busy    (busy[g]),
      .o_irq     (irq[g])
    );
  end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Scoreboard bench for timer_multi_ch: directed stimulus pushes per-edge
// expectations; a monitor pops and compares them one step after each edge.
module tb_timer_multi_ch;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int PSC_W = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [PSC_W-1:0]      cfg_psc = '0;
  logic [N_CH-1:0]       ch_en = '0;
  logic [2*N_CH-1:0]     ch_mode = '0;
  logic [CNT_W*N_CH-1:0] ch_max = '0;
  logic [N_CH-1:0]       ch_trig = '0;
  logic [N_CH-1:0]       irq_clr = '0;
  logic [CNT_W*N_CH-1:0] cnt;
  logic [N_CH-1:0]       expire;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       irq;

  timer_multi_ch #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_psc (cfg_psc),
    .ch_en   (ch_en),
    .ch_mode (ch_mode),
    .ch_max  (ch_max),
    .ch_trig (ch_trig),
    .irq_clr (irq_clr),
    .cnt     (cnt),
    .expire  (expire),
    .busy    (busy),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          ch;
    logic [31:0] c;
    logic        e;
    logic        b;
    logic        q;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Hand-computed expectation tables (index = edge number - 1)
  int t1_irq [14] = '{0,0,0,1,0,0,0,1,1,1,1,1,0,0};
  int t2_cnt [8]  = '{5,4,3,2,1,0,5,4};
  int t3_cnt [10] = '{0,0,1,2,3,4,4,4,0,1};
  int t3_exp [10] = '{0,0,0,0,0,0,1,0,0,0};
  int t3_bsy [10] = '{0,1,1,1,1,1,0,0,1,1};
  int t4_cnt [10] = '{1,2,1,0,1,2,1,0,1,0};
  int t4_exp [10] = '{0,1,0,0,0,1,1,0,1,0};

  task automatic push(input string nm, input int ch, input logic [31:0] c,
                      input logic e, input logic b, input logic q);
    exp_t x;
    x.cyc = cyc + 1;
    x.ch  = ch;
    x.c   = c;
    x.e   = e;
    x.b   = b;
    x.q   = q;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [31:0] v);
    ch_mode[2*ch +: 2]    = m;
    ch_max[CNT_W*ch +: 32] = v;
  endtask

  exp_t        mx;
  logic [31:0] mc;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mx = sb.pop_front();
      mc = cnt[CNT_W*mx.ch +: 32];
      n_chk = n_chk + 1;
      if (mx.cyc != cyc) begin
        $display("FAIL %s ch%0d: expectation for cyc %0d not checked in time (now %0d)",
                 mx.nm, mx.ch, mx.cyc, cyc);
      end else if (mc !== mx.c || expire[mx.ch] !== mx.e ||
                   busy[mx.ch] !== mx.b || irq[mx.ch] !== mx.q) begin
        $display("FAIL %s ch%0d cyc%0d: got cnt=%0d exp=%b busy=%b irq=%b, want cnt=%0d exp=%b busy=%b irq=%b",
                 mx.nm, mx.ch, cyc, mc, expire[mx.ch], busy[mx.ch], irq[mx.ch],
                 mx.c, mx.e, mx.b, mx.q);
      end else begin
        n_pass = n_pass + 1;
      end
    end
  end

  initial begin
    // reset state
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) push("reset", c, 0, 0, 0, 0);

    // 1: REPEAT_UP max=3, psc=0, irq clear and set-wins
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 1) begin
        rst = 1'b0;
        set_ch(0, 2'b00, 3);
        ch_en = 4'b0001;
      end
      irq_clr[0] = (j == 5 || j == 12 || j == 13);
      push("rep_up", 0, 32'(j % 4), (j % 4) == 0, 1'b1, t1_irq[j-1] != 0);
    end
    @(negedge clk);
    irq_clr = '0;
    ch_en   = '0;
    push("disable", 0, 0, 0, 0, 0);

    // 2: DOWN max=5 with psc=2
    @(negedge clk);
    cfg_psc = 2;
    set_ch(1, 2'b10, 5);
    push("down_idle", 1, 5, 0, 0, 0);
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      if (j == 1) ch_en = 4'b0010;
      push("down", 1, 32'(t2_cnt[j/3]), j == 18, 1'b1, j >= 18);
    end
    @(negedge clk);
    ch_en   = '0;
    cfg_psc = 0;
    push("down_off", 1, 5, 0, 0, 1);

    // 3: ONESHOT max=4, trig ignored while busy, retrig after done
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) begin
        set_ch(2, 2'b01, 4);
        ch_en = 4'b0100;
      end
      ch_trig[2] = (j == 2 || j == 5 || j == 9);
      push("oneshot", 2, 32'(t3_cnt[j-1]), t3_exp[j-1] != 0,
           t3_bsy[j-1] != 0, j >= 7);
    end
    @(negedge clk);
    ch_trig = '0;
    ch_en   = '0;
    push("oneshot_off", 2, 0, 0, 0, 1);

    // 4: UPDOWN max=2, then max lowered to 1 while at 2
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) begin
        set_ch(3, 2'b11, 2);
        ch_en = 4'b1000;
      end
      if (j == 7) set_ch(3, 2'b11, 1);
      push("updown", 3, 32'(t4_cnt[j-1]), t4_exp[j-1] != 0, 1'b1, j >= 2);
    end
    @(negedge clk);
    ch_en = '0;
    push("updown_off", 3, 0, 0, 0, 1);

    // 6: reset with all channels mid-count, then resume
    @(negedge clk);
    irq_clr = 4'b1111;
    set_ch(0, 2'b00, 100);
    set_ch(1, 2'b10, 100);
    set_ch(2, 2'b01, 100);
    set_ch(3, 2'b11, 100);
    push("pre_all", 0, 0, 0, 0, 0);
    push("pre_all", 1, 100, 0, 0, 0);
    push("pre_all", 2, 0, 0, 0, 0);
    push("pre_all", 3, 0, 0, 0, 0);
    @(negedge clk);
    irq_clr = '0;
    ch_en   = 4'b1111;
    ch_trig = 4'b0100;
    @(negedge clk);
    ch_trig = '0;
    @(negedge clk);
    @(negedge clk);
    push("mid_all", 0, 4, 0, 1, 0);
    push("mid_all", 1, 96, 0, 1, 0);
    push("mid_all", 2, 3, 0, 1, 0);
    push("mid_all", 3, 4, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < N_CH; c++) push("rst_mid", c, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    push("resume", 0, 1, 0, 1, 0);
    push("resume", 1, 100, 1, 1, 1);
    push("resume", 2, 0, 0, 0, 0);
    push("resume", 3, 1, 0, 1, 0);

    // max=0 in REPEAT_UP: expire every tick with cnt=0
    @(negedge clk);
    ch_en = 4'b0001;
    set_ch(0, 2'b00, 0);
    push("max0", 0, 0, 1, 1, 1);
    @(negedge clk);
    push("max0", 0, 0, 1, 1, 1);
    @(negedge clk);
    ch_en = '0;

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk = n_chk + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
